// File: rtl/nr_pkg.sv
// Shared constants and types for the Newton-Raphson datapath blocks:
// operand address map, FP word width and the matvec sequencer state encoding.
package nr_pkg;
   localparam int FP_W        = 32;
   localparam int ADDR_W      = 5;
   localparam int ROW_W       = 2;
   localparam int N_LANE      = 4;
   localparam int ADDR_A_BASE = 0;
   localparam int ADDR_X_BASE = 16;
   localparam int RF_DEPTH    = 20;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_t;
endpackage

// File: rtl/matvec_operand_rf.sv
// 20x32 operand storage for the 4x4 matrix A and vector x, with write decode
// and a row-select read port that presents one row of A alongside x.
module matvec_operand_rf
   import nr_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [FP_W-1:0]   wr_data,
   input  logic [ROW_W-1:0]  row,
   input  logic              rd_en,
   output logic [FP_W-1:0]   a0,
   output logic [FP_W-1:0]   a1,
   output logic [FP_W-1:0]   a2,
   output logic [FP_W-1:0]   a3,
   output logic [FP_W-1:0]   b0,
   output logic [FP_W-1:0]   b1,
   output logic [FP_W-1:0]   b2,
   output logic [FP_W-1:0]   b3
);

   logic [FP_W-1:0] mem [RF_DEPTH];

   // Addresses 20..31 fall outside the map and are dropped.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < RF_DEPTH; i++) mem[i] <= '0;
      end else if (wr_en && (wr_addr < ADDR_W'(RF_DEPTH))) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign a0 = rd_en ? mem[{1'b0, row, 2'b00}] : '0;
   assign a1 = rd_en ? mem[{1'b0, row, 2'b01}] : '0;
   assign a2 = rd_en ? mem[{1'b0, row, 2'b10}] : '0;
   assign a3 = rd_en ? mem[{1'b0, row, 2'b11}] : '0;
   assign b0 = rd_en ? mem[ADDR_X_BASE + 0] : '0;
   assign b1 = rd_en ? mem[ADDR_X_BASE + 1] : '0;
   assign b2 = rd_en ? mem[ADDR_X_BASE + 2] : '0;
   assign b3 = rd_en ? mem[ADDR_X_BASE + 3] : '0;

endmodule

// File: rtl/matvec_4x4_seq.sv
// y = A*x sequencer: steps the external dot-product unit through the four rows
// of A, holding each row for DOT_LATENCY cycles and capturing the result into y[row].
module matvec_4x4_seq
   import nr_pkg::*;
#(
   parameter int DOT_LATENCY = 16,
   parameter int CNT_W       = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_en,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [FP_W-1:0]   load_data,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic [FP_W-1:0]   dot_a0,
   output logic [FP_W-1:0]   dot_a1,
   output logic [FP_W-1:0]   dot_a2,
   output logic [FP_W-1:0]   dot_a3,
   output logic [FP_W-1:0]   dot_b0,
   output logic [FP_W-1:0]   dot_b1,
   output logic [FP_W-1:0]   dot_b2,
   output logic [FP_W-1:0]   dot_b3,
   input  logic [FP_W-1:0]   dot_out,
   output logic [FP_W-1:0]   y0,
   output logic [FP_W-1:0]   y1,
   output logic [FP_W-1:0]   y2,
   output logic [FP_W-1:0]   y3
);

   localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(DOT_LATENCY - 1);
   localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(N_LANE - 1);

   state_t           state, state_next;
   logic [ROW_W-1:0] row, row_next;
   logic [CNT_W-1:0] cnt, cnt_next;
   logic             capture;
   logic             wr_en;
   logic [FP_W-1:0]  y_reg [N_LANE];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         row   <= '0;
         cnt   <= '0;
      end else begin
         state <= state_next;
         row   <= row_next;
         cnt   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state;
      row_next   = row;
      cnt_next   = cnt;
      capture    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = WAIT;
               row_next   = '0;
               cnt_next   = CNT_RELOAD;
            end
         end
         WAIT: begin
            if (cnt != '0) begin
               cnt_next = cnt - 1'b1;
            end else begin
               capture = 1'b1;
               if (row != ROW_LAST) begin
                  row_next = row + 1'b1;
                  cnt_next = CNT_RELOAD;
               end else begin
                  state_next = DONE;
               end
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign busy  = (state != IDLE);
   assign done  = (state == DONE);
   // Operands are frozen while a pass runs so the dot unit sees stable inputs.
   assign wr_en = load_en && (state == IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < N_LANE; i++) y_reg[i] <= '0;
      end else if (capture) begin
         y_reg[row] <= dot_out;
      end
   end

   assign y0 = y_reg[0];
   assign y1 = y_reg[1];
   assign y2 = y_reg[2];
   assign y3 = y_reg[3];

   matvec_operand_rf u_rf (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_addr (load_addr),
      .wr_data (load_data),
      .row     (row),
      .rd_en   (state == WAIT),
      .a0      (dot_a0),
      .a1      (dot_a1),
      .a2      (dot_a2),
      .a3      (dot_a3),
      .b0      (dot_b0),
      .b1      (dot_b1),
      .b2      (dot_b2),
      .b3      (dot_b3)
   );

endmodule
